board_loader: RTL and testbench

- Host-side producer for the vchess board input. Accepts square-granular commands over a valid/ready interface, assembles the 64-square board image, and presents it to vchess.
- Commit emits a one-cycle board_valid pulse and latches white_to_move. The board is then frozen for a hold-off window so the consumer can sample it.
- Sits between the host/register bridge and the vchess board, board_valid and white_to_move inputs.

---
 rtl/board_loader_if.sv | 28 ++
 rtl/board_loader.sv | 98 +++++++++
 tb/tb_board_loader.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/board_loader_if.sv
// board_loader_if: command channel and board outputs between the host bridge and board_loader
interface board_loader_if #(
    parameter int PIECE_WIDTH = 4
);
    localparam int BOARD_WIDTH = PIECE_WIDTH * 64;

    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [1:0]             cmd_op;
    logic [5:0]             cmd_square;
    logic [PIECE_WIDTH-1:0] cmd_piece;
    logic                   cmd_white_to_move;
    logic                   rd_valid;
    logic [PIECE_WIDTH-1:0] rd_piece;
    logic [BOARD_WIDTH-1:0] board;
    logic                   board_valid;
    logic                   white_to_move;

    modport master (
        output cmd_valid, cmd_op, cmd_square, cmd_piece, cmd_white_to_move,
        input  cmd_ready, rd_valid, rd_piece, board, board_valid, white_to_move
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_square, cmd_piece, cmd_white_to_move,
        output cmd_ready, rd_valid, rd_piece, board, board_valid, white_to_move
    );
endinterface

// File: rtl/board_loader.sv
// board_loader: assembles a 64-square board from host commands and presents it with a commit pulse
module board_loader #(
    parameter int                     PIECE_WIDTH = 4,
    parameter int                     SIDE_WIDTH  = PIECE_WIDTH * 8,
    parameter int                     BOARD_WIDTH = PIECE_WIDTH * 64,
    parameter logic [PIECE_WIDTH-1:0] EMPTY_CODE  = '0,
    parameter int                     HOLDOFF     = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    board_loader_if.slave bus
);
    localparam int CW = HOLDOFF > 1 ? $clog2(HOLDOFF) : 1;

    typedef enum logic [1:0] {IDLE, CLEAR, HOLD} state_t;

    state_t                 state_q, state_d;
    logic [2:0]             rank_q, rank_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BOARD_WIDTH-1:0] board_q, board_d;
    logic                   wtm_q, wtm_d;
    logic                   bv_q, bv_d;
    logic                   rv_q, rv_d;
    logic [PIECE_WIDTH-1:0] rd_q, rd_d;

    assign bus.cmd_ready     = state_q == IDLE;
    assign bus.board         = board_q;
    assign bus.board_valid   = bv_q;
    assign bus.white_to_move = wtm_q;
    assign bus.rd_valid      = rv_q;
    assign bus.rd_piece      = rd_q;

    // Command decode in IDLE, rank-by-rank wipe in CLEAR, frozen countdown in HOLD
    always_comb begin
        state_d = state_q;
        rank_d  = rank_q;
        cnt_d   = cnt_q;
        board_d = board_q;
        wtm_d   = wtm_q;
        bv_d    = 1'b0;
        rv_d    = 1'b0;
        rd_d    = rd_q;
        case (state_q)
            IDLE: if (bus.cmd_valid) begin
                case (bus.cmd_op)
                    2'd0: board_d[bus.cmd_square*PIECE_WIDTH +: PIECE_WIDTH] = bus.cmd_piece;
                    2'd1: begin
                        state_d = CLEAR;
                        rank_d  = '0;
                    end
                    2'd2: begin
                        state_d = HOLD;
                        cnt_d   = CW'(HOLDOFF - 1);
                        wtm_d   = bus.cmd_white_to_move;
                        bv_d    = 1'b1;
                    end
                    default: begin
                        rd_d = board_q[bus.cmd_square*PIECE_WIDTH +: PIECE_WIDTH];
                        rv_d = 1'b1;
                    end
                endcase
            end
            CLEAR: begin
                board_d[rank_q*SIDE_WIDTH +: SIDE_WIDTH] = {8{EMPTY_CODE}};
                rank_d = rank_q + 3'd1;
                state_d = rank_q == 3'd7 ? IDLE : CLEAR;
            end
            HOLD: begin
                cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
                state_d = cnt_q == '0 ? IDLE : HOLD;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset empties the board and aborts any operation
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rank_q  <= '0;
            cnt_q   <= '0;
            board_q <= {64{EMPTY_CODE}};
            wtm_q   <= 1'b1;
            bv_q    <= 1'b0;
            rv_q    <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            rank_q  <= rank_d;
            cnt_q   <= cnt_d;
            board_q <= board_d;
            wtm_q   <= wtm_d;
            bv_q    <= bv_d;
            rv_q    <= rv_d;
            rd_q    <= rd_d;
        end
    end
endmodule

// File: tb/tb_board_loader.sv
// tb_board_loader: directed and random command sequences checked against an array model of the board
module tb_board_loader;
    localparam int PW = 4;
    localparam int HOLDOFF = 8;
    localparam logic [PW-1:0] EMPTY = 4'd0;
    localparam logic [PW-1:0] WP = 4'd1, WN = 4'd2, WB = 4'd3, WR = 4'd4, WQ = 4'd5, WK = 4'd6;
    localparam logic [PW-1:0] BP = 4'd9, BN = 4'd10, BB = 4'd11, BR = 4'd12, BQ = 4'd13, BK = 4'd14;
    localparam logic [1:0] OP_W = 2'd0, OP_C = 2'd1, OP_M = 2'd2, OP_R = 2'd3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int vectors = 0;
    int errors = 0;

    logic [PW-1:0] mb [64];
    logic          mwtm;
    logic [PW-1:0] rd_exp;
    logic [PW-1:0] back_rank [8];

    board_loader_if #(.PIECE_WIDTH(PW)) bus ();

    board_loader #(.PIECE_WIDTH(PW), .EMPTY_CODE(EMPTY), .HOLDOFF(HOLDOFF)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] want);
        vectors++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    function automatic logic [255:0] exp_board();
        logic [255:0] v;
        for (int i = 0; i < 64; i++) v[i*PW +: PW] = mb[i];
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) mb[i] = EMPTY;
        mwtm = 1'b1;
    endfunction

    function automatic logic [PW-1:0] apply(input logic [1:0] op, input int sq, input logic [PW-1:0] pc, input logic w);
        logic [PW-1:0] r;
        r = mb[sq];
        if (op == OP_W) mb[sq] = pc;
        if (op == OP_C) for (int i = 0; i < 64; i++) mb[i] = EMPTY;
        if (op == OP_M) mwtm = w;
        return r;
    endfunction

    // Called at a negedge; returns at the negedge one cycle after the accepting posedge.
    task automatic send(input logic [1:0] op, input int sq, input logic [PW-1:0] pc, input logic w, output int waited);
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op;
        bus.cmd_square = 6'(sq);
        bus.cmd_piece = pc;
        bus.cmd_white_to_move = w;
        waited = 0;
        while (!bus.cmd_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_timeout", waited < 40, 1'b1);
        rd_exp = apply(op, sq, pc, w);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        int w;
        int n;
        int stalls;
        logic [255:0] snap;
        logic [1:0] op;
        int sq;
        logic [PW-1:0] pc;
        logic wt;
        int r;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = OP_W;
        bus.cmd_square = '0;
        bus.cmd_piece = '0;
        bus.cmd_white_to_move = 1'b0;
        back_rank = '{WR, WN, WB, WQ, WK, WB, WN, WR};
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_board", bus.board, exp_board());
        chk("rst_wtm", bus.white_to_move, 1'b1);
        chk("rst_ready", bus.cmd_ready, 1'b1);
        chk("rst_bv", bus.board_valid, 1'b0);
        chk("rst_rv", bus.rd_valid, 1'b0);
        chk("rst_rdp", bus.rd_piece, '0);
        reset_n = 1'b1;
        @(negedge clk);

        // 1: single write then commit
        send(OP_W, 1, WN, 1'b0, w);
        chk("t1_write_vis", bus.board, exp_board());
        send(OP_M, 0, '0, 1'b1, w);
        chk("t1_bv", bus.board_valid, 1'b1);
        chk("t1_board", bus.board, exp_board());
        chk("t1_sq1", bus.board[1*PW +: PW], WN);
        chk("t1_wtm", bus.white_to_move, 1'b1);
        n = 0;
        while (!bus.cmd_ready && n < 40) begin
            @(negedge clk);
            n++;
            chk("t1_bv_once", bus.board_valid, 1'b0);
        end
        chk("t1_hold_len", n, HOLDOFF);

        // 2: start position, back-to-back writes
        stalls = 0;
        for (int f = 0; f < 8; f++) begin
            send(OP_W, f, back_rank[f], 1'b0, w); stalls += w;
            send(OP_W, 8 + f, WP, 1'b0, w); stalls += w;
            send(OP_W, 48 + f, BP, 1'b0, w); stalls += w;
            send(OP_W, 56 + f, back_rank[f] | 4'd8, 1'b0, w); stalls += w;
        end
        chk("t2_stalls", stalls, 0);
        send(OP_M, 0, '0, 1'b0, w);
        chk("t2_bv", bus.board_valid, 1'b1);
        chk("t2_board", bus.board, exp_board());
        chk("t2_wtm", bus.white_to_move, 1'b0);
        chk("t2_bk", bus.board[60*PW +: PW], BK);

        // 3: clear then a held READ 60
        send(OP_R, 60, '0, 1'b0, w);
        chk("t3_pre_rd", bus.rd_piece, BK);
        send(OP_C, 0, '0, 1'b0, w);
        send(OP_R, 60, '0, 1'b0, w);
        chk("t3_clear_len", w, 8);
        chk("t3_rv", bus.rd_valid, 1'b1);
        chk("t3_rdp", bus.rd_piece, EMPTY);
        chk("t3_board", bus.board, exp_board());
        @(negedge clk);
        chk("t3_rv_once", bus.rd_valid, 1'b0);

        // 4: read-after-write and read-before-write ordering
        send(OP_W, 12, WP, 1'b0, w);
        send(OP_R, 12, '0, 1'b0, w);
        chk("t4_rdp", bus.rd_piece, WP);
        chk("t4_rv", bus.rd_valid, 1'b1);
        send(OP_R, 12, '0, 1'b0, w);
        chk("t4_rv2", bus.rd_valid, 1'b1);
        send(OP_W, 12, BP, 1'b0, w);
        chk("t4_rdp_prior", bus.rd_piece, WP);
        chk("t4_rv_drop", bus.rd_valid, 1'b0);
        chk("t4_sq12", bus.board[12*PW +: PW], BP);

        // 5: write blocked during hold
        send(OP_M, 0, '0, 1'b1, w);
        snap = bus.board;
        bus.cmd_valid = 1'b1;
        bus.cmd_op = OP_W;
        bus.cmd_square = 6'd0;
        bus.cmd_piece = WR;
        n = 0;
        while (!bus.cmd_ready && n < 40) begin
            chk("t5_frozen", bus.board, snap);
            @(negedge clk);
            n++;
        end
        rd_exp = apply(OP_W, 0, WR, 1'b0);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("t5_hold_len", n, HOLDOFF);
        chk("t5_applied", bus.board, exp_board());

        // 6a: reset mid-CLEAR
        send(OP_W, 63, BK, 1'b0, w);
        send(OP_C, 0, '0, 1'b0, w);
        repeat (3) @(negedge clk);
        chk("t6_mid_clear", bus.board[63*PW +: PW], BK);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("t6a_board", bus.board, exp_board());
        chk("t6a_ready", bus.cmd_ready, 1'b1);
        chk("t6a_rdp", bus.rd_piece, '0);
        @(negedge clk);
        reset_n = 1'b1;
        // 6b: reset mid-HOLD
        @(negedge clk);
        send(OP_W, 5, WQ, 1'b0, w);
        send(OP_M, 0, '0, 1'b0, w);
        repeat (3) @(negedge clk);
        chk("t6_mid_hold_wtm", bus.white_to_move, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("t6b_board", bus.board, exp_board());
        chk("t6b_wtm", bus.white_to_move, 1'b1);
        chk("t6b_ready", bus.cmd_ready, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("t6_post_bv", bus.board_valid, 1'b0);
            chk("t6_post_ready", bus.cmd_ready, 1'b1);
            chk("t6_post_board", bus.board, exp_board());
        end

        // random command stream
        for (int k = 0; k < 150; k++) begin
            r = int'($urandom_range(0, 15));
            op = r == 0 ? OP_C : r == 1 ? OP_M : r < 9 ? OP_W : OP_R;
            sq = int'($urandom_range(0, 63));
            pc = PW'($urandom);
            wt = 1'($urandom);
            send(op, sq, pc, wt, w);
            chk("rnd_excl", bus.board_valid & bus.rd_valid, 1'b0);
            chk("rnd_bv", bus.board_valid, op == OP_M);
            chk("rnd_rv", bus.rd_valid, op == OP_R);
            if (op != OP_C) chk("rnd_board", bus.board, exp_board());
            if (op == OP_R) chk("rnd_rdp", bus.rd_piece, rd_exp);
            chk("rnd_wtm", bus.white_to_move, mwtm);
            repeat (int'($urandom_range(0, 1))) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
